// File: rtl/z_alu_seq.sv
// z_alu_seq: multi-cycle execute controller sequencing z_ALU and a sync-read register file
module z_alu_seq #(
  parameter int RF_LAT = 1,
  parameter int W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         ins_valid_in,
  output logic         ins_ready_out,
  input  logic [31:0]  ins_in,
  output logic [4:0]   rf_raddr1_out,
  output logic [4:0]   rf_raddr2_out,
  input  logic [W-1:0] rf_rdata1_in,
  input  logic [W-1:0] rf_rdata2_in,
  output logic [W-1:0] alu_a_out,
  output logic [W-1:0] alu_b_out,
  output logic [4:0]   alu_shamt_out,
  output logic [31:0]  alu_ins_out,
  input  logic [W-1:0] alu_result_in,
  input  logic         alu_zero_in,
  output logic         rf_we_out,
  output logic [4:0]   rf_waddr_out,
  output logic [W-1:0] rf_wdata_out,
  output logic         done_out,
  output logic         branch_taken_out,
  output logic         illegal_out
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
  state_t state;
  logic [1:0] cnt;
  logic [31:0] ins_q, ins_d;
  logic [5:0] op, funct;
  logic [15:0] imm;
  logic is_r, is_ari, is_log, is_lui, is_beq, is_bne, wr;
  logic [W-1:0] a_d, b_d;
  logic [4:0] waddr_d;
  assign ins_ready_out = state == IDLE && !rst_in;
  always_comb begin
    op = ins_q[31:26];
    imm = ins_q[15:0];
    is_r = op == 6'b000000;
    is_ari = op == 6'b001000 || op == 6'b001010;
    is_log = op inside {6'b001100, 6'b001101, 6'b001110};
    is_lui = op == 6'b001111;
    is_beq = op == 6'b000100;
    is_bne = op == 6'b000101;
    wr = is_r | is_ari | is_log | is_lui;
    funct = op == 6'b001000 ? 6'b100000 :
            op == 6'b001010 ? 6'b101010 :
            op == 6'b001100 ? 6'b100100 :
            op == 6'b001101 ? 6'b100101 :
            op == 6'b001110 ? 6'b100110 :
            is_lui          ? 6'b100101 : 6'b100010;
    ins_d = (is_r || !(wr || is_beq || is_bne)) ? ins_q : {6'b0, ins_q[25:16], 10'b0, funct};
    a_d = is_lui ? '0 : rf_rdata1_in;
    b_d = is_ari ? {{16{imm[15]}}, imm} : is_log ? {16'h0, imm} : is_lui ? {imm, 16'h0} : rf_rdata2_in;
    waddr_d = is_r ? ins_q[15:11] : ins_q[20:16];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      ins_q <= '0;
      rf_raddr1_out <= '0;
      rf_raddr2_out <= '0;
      alu_a_out <= '0;
      alu_b_out <= '0;
      alu_shamt_out <= '0;
      alu_ins_out <= '0;
      rf_we_out <= 1'b0;
      rf_waddr_out <= '0;
      rf_wdata_out <= '0;
      done_out <= 1'b0;
      branch_taken_out <= 1'b0;
      illegal_out <= 1'b0;
    end else begin
      rf_we_out <= 1'b0;
      done_out <= 1'b0;
      branch_taken_out <= 1'b0;
      illegal_out <= 1'b0;
      case (state)
        IDLE: if (ins_valid_in) begin
          ins_q <= ins_in;
          rf_raddr1_out <= ins_in[25:21];
          rf_raddr2_out <= ins_in[20:16];
          cnt <= 2'(RF_LAT - 1);
          state <= FETCH;
        end
        FETCH: if (cnt == 2'd0) begin
          alu_a_out <= a_d;
          alu_b_out <= b_d;
          alu_shamt_out <= is_r ? ins_q[10:6] : 5'd0;
          alu_ins_out <= ins_d;
          state <= EXEC;
        end else cnt <= cnt - 2'd1;
        EXEC: begin
          rf_wdata_out <= alu_result_in;
          rf_waddr_out <= waddr_d;
          rf_we_out <= wr && waddr_d != 5'd0;
          done_out <= 1'b1;
          branch_taken_out <= is_beq ? alu_zero_in : is_bne ? !alu_zero_in : 1'b0;
          illegal_out <= !(wr || is_beq || is_bne);
          state <= WB;
        end
        WB: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z_alu_seq.sv
// tb_z_alu_seq: scoreboard bench for z_alu_seq at RF_LAT 1 and 3
module tb_z_alu_seq;
  logic clk = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] ins, wd, a, b, ai;
    logic wr, we, br, ill;
    logic [4:0] wa, sh;
    int t;
  } exp_t;

  task automatic chk(input int lane, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL lane%0d %s: got %h expected %h", lane, name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_f(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    case (f)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2a: return {31'b0, $signed(a) < $signed(b)};
      6'h00: return b << sh;
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t ref_m(input logic [31:0] x, input logic [31:0] rs_v, input logic [31:0] rt_v);
    exp_t e;
    logic [15:0] imm = x[15:0];
    logic [31:0] se = {{16{imm[15]}}, imm};
    logic [31:0] ze = {16'h0, imm};
    e = '{default: 0};
    e.ins = x;
    e.a = rs_v;
    e.b = rt_v;
    e.ai = {6'b0, x[25:16], 16'h0};
    e.wa = x[20:16];
    case (x[31:26])
      6'h00: begin e.ai = x; e.sh = x[10:6]; e.wa = x[15:11]; e.wr = 1; e.wd = alu_f(x[5:0], rs_v, rt_v, x[10:6]); end
      6'h08: begin e.b = se; e.ai[5:0] = 6'h20; e.wr = 1; e.wd = rs_v + se; end
      6'h0a: begin e.b = se; e.ai[5:0] = 6'h2a; e.wr = 1; e.wd = {31'b0, $signed(rs_v) < $signed(se)}; end
      6'h0c: begin e.b = ze; e.ai[5:0] = 6'h24; e.wr = 1; e.wd = rs_v & ze; end
      6'h0d: begin e.b = ze; e.ai[5:0] = 6'h25; e.wr = 1; e.wd = rs_v | ze; end
      6'h0e: begin e.b = ze; e.ai[5:0] = 6'h26; e.wr = 1; e.wd = rs_v ^ ze; end
      6'h0f: begin e.a = 0; e.b = {imm, 16'h0}; e.ai[5:0] = 6'h25; e.wr = 1; e.wd = {imm, 16'h0}; end
      6'h04: begin e.ai[5:0] = 6'h22; e.br = rs_v == rt_v; end
      6'h05: begin e.ai[5:0] = 6'h22; e.br = rs_v != rt_v; end
      default: e.ill = 1;
    endcase
    e.we = e.wr && e.wa != 0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h04, 6'h05, 6'h3f, 6'h23};
    logic [5:0] fs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00};
    logic [5:0] op = ops[$urandom_range(0, 11)];
    logic [4:0] rs = 5'($urandom);
    logic [4:0] rt = $urandom_range(0, 3) == 0 ? rs : 5'($urandom);
    logic [4:0] rd = $urandom_range(0, 4) == 0 ? 5'd0 : 5'($urandom);
    return op == 6'h00 ? {op, rs, rt, rd, 5'($urandom), fs[$urandom_range(0, 7)]} : {op, rs, rt, 16'($urandom)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int L = g ? 3 : 1;
    logic rst, valid, ready, we, done, br, ill, zero;
    logic [31:0] ins, rd1, rd2, a, b, ai, res, wd;
    logic [4:0] ra1, ra2, sh, wa;
    logic [31:0] rf [32];
    logic [31:0] mdl [32];
    logic [4:0] d1 [4];
    logic [4:0] d2 [4];
    exp_t q[$];
    int cyc = 0;
    int prev = -1;
    bit stream = 0;
    bit fin = 0;

    z_alu_seq #(.RF_LAT(L), .W(32)) dut (
      .clk_in(clk), .rst_in(rst), .ins_valid_in(valid), .ins_ready_out(ready), .ins_in(ins),
      .rf_raddr1_out(ra1), .rf_raddr2_out(ra2), .rf_rdata1_in(rd1), .rf_rdata2_in(rd2),
      .alu_a_out(a), .alu_b_out(b), .alu_shamt_out(sh), .alu_ins_out(ai),
      .alu_result_in(res), .alu_zero_in(zero),
      .rf_we_out(we), .rf_waddr_out(wa), .rf_wdata_out(wd),
      .done_out(done), .branch_taken_out(br), .illegal_out(ill)
    );

    assign rd1 = L == 1 ? rf[ra1] : rf[d1[L > 1 ? L - 2 : 0]];
    assign rd2 = L == 1 ? rf[ra2] : rf[d2[L > 1 ? L - 2 : 0]];
    assign res = alu_f(ai[5:0], a, b, sh);
    assign zero = res == 32'h0;

    always @(posedge clk) begin
      cyc <= cyc + 1;
      d1[0] <= ra1;
      d2[0] <= ra2;
      for (int i = 1; i < 4; i++) begin
        d1[i] <= d1[i-1];
        d2[i] <= d2[i-1];
      end
      if (rst) rf <= mdl;
      else if (we) rf[wa] <= wd;
    end

    initial forever begin
      @(negedge clk);
      if (!rst && valid && ready) begin
        exp_t e;
        e = ref_m(ins, mdl[ins[25:21]], mdl[ins[20:16]]);
        e.t = cyc;
        if (stream && prev >= 0) chk(g, "accept_spacing", cyc - prev, L + 3);
        prev = cyc;
        q.push_back(e);
      end
    end

    initial begin
      exp_t e;
      for (int i = 0; i < 32; i++) mdl[i] = i == 0 ? 32'h0 : $urandom;
      mdl[1] = 32'd5;
      mdl[31] = 32'h14D5A6BB;
      mdl[6] = mdl[5];
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          chk(g, "rst_strobes", {ready, done, we, br, ill}, 0);
        end else if (done) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL lane%0d unexpected_done: got done with ins_out %h, expected none", g, ai);
          end else begin
            e = q.pop_front();
            chk(g, "ready_with_done", ready, 0);
            chk(g, "latency", cyc - e.t, L + 2);
            chk(g, "rf_we", we, e.we);
            chk(g, "branch", br, e.br);
            chk(g, "illegal", ill, e.ill);
            if (e.wr) begin
              chk(g, "waddr", wa, e.wa);
              chk(g, "wdata", wd, e.wd);
            end
            if (!e.ill) begin
              chk(g, "alu_a", a, e.a);
              chk(g, "alu_b", b, e.b);
              chk(g, "alu_ins", ai, e.ai);
              chk(g, "alu_shamt", sh, e.sh);
            end
            if (e.we) mdl[e.wa] = e.wd;
          end
        end else chk(g, "idle_strobes", {br, ill, we}, 0);
      end
    end

    task automatic send(input logic [31:0] x);
      bit ok = 0;
      ins = x;
      valid = 1;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = ready;
      end
      chk(g, "accept_timeout", ok, 1);
      @(posedge clk);
      #1;
    endtask

    initial begin
      logic [31:0] dir [8] = '{32'h03E0F823, 32'h2022FFFF, 32'h3C03ABCD, 32'h34848001,
                               32'h10A60000, 32'h14A60000, 32'h00220020, 32'hFC000000};
      rst = 1;
      valid = 0;
      ins = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(g, "rst_outputs", a | b | ai | wd | {12'h0, ra1, ra2, sh, wa}, 0);
      @(posedge clk);
      #1 rst = 0;
      stream = 1;
      foreach (dir[i]) send(dir[i]);
      repeat (30) send(rnd_ins());
      stream = 0;
      valid = 0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      chk(g, "drain", q.size(), 0);
      send(32'h20070009);
      valid = 0;
      repeat (L) @(posedge clk);
      #1 rst = 1;
      @(negedge clk);
      chk(g, "ready_in_rst", ready, 0);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk(g, "ready_after_rst", ready, 1);
      repeat (L + 4) @(negedge clk);
      @(posedge clk);
      #1;
      send(32'h2008000B);
      valid = 0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      chk(g, "drain_after_rst", q.size(), 0);
      send(32'h01074020);
      valid = 0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      chk(g, "final_drain", q.size(), 0);
      fin = 1;
    end
  end

  initial begin
    wait (g_lane[0].fin && g_lane[1].fin);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
endmodule
